mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single external memory bus between the instruction-fetch requester (IF stage) and the data requester (MEM stage, fed by the ex_mem pipeline register). It runs a one-transaction-at-a-time bus state machine, registers read data, and raises a stall request to the pipeline controller while either requester waits. MEM has fixed priority over IF; an IF flush discards an in-flight fetch response.

## Interface
- TIMEOUT_CYCLES, 255: cycles bus_req_o may stay high without bus_ack_i before abort (only with the macro below); range 1–255.

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (rst==0 resets immediately)
- if_req_i  in  1  fetch request, held until if_done_o
- if_addr_i  in  32  fetch address
- if_done_o  out  1  one-cycle pulse, if_rdata_o valid
- if_rdata_o  out  32  fetched word
- mem_req_i  in  1  data request, held until mem_done_o
- mem_we_i  in  1  1=store, 0=load
- mem_addr_i  in  32  data address
- mem_wdata_i  in  32  store data
- mem_sel_i  in  4  byte enables
- mem_done_o  out  1  one-cycle pulse, mem_rdata_o valid
- mem_rdata_o  out  32  load data (0 for stores)
- flush_i  in  1  pipeline flush; cancels IF request/response
- stallreq_o  out  1  to pipeline controller
- err_o  out  1  one-cycle pulse with a done pulse on timeout abort
- bus_req_o, bus_we_o  out  1  bus strobe / write
- bus_addr_o, bus_wdata_o  out  32  bus address / write data
- bus_sel_o  out  4  bus byte enables
- bus_ack_i  in  1  transaction complete (sampled only while bus_req_o=1)
- bus_rdata_i  in  32  read data, valid with bus_ack_i

## Operation
- States: IDLE, BUS, RESP.
- IDLE: if mem_req_i → latch MEM fields onto bus_* registers, owner=MEM, go BUS. Else if if_req_i && !flush_i → latch IF fields (bus_we_o=0, bus_sel_o=4'hF), owner=IF, go BUS. Else stay.
- Both requests in IDLE same cycle: MEM wins; IF served next IDLE.
- BUS: bus_req_o=1, bus_* held constant. On bus_ack_i: capture bus_rdata_i (0 if write) into owner's rdata register, go RESP.
- RESP: pulse owner's done (unless discarded), bus_req_o=0, go IDLE.
- flush_i while owner=IF in BUS or RESP: set discard flag; transaction completes on bus normally, if_done_o suppressed, if_rdata_o unchanged. flush_i never affects MEM transactions.
- stallreq_o = (if_req_i && !if_done_o && !flush_i) || (mem_req_i && !mem_done_o), combinational.
- Requester rule (guaranteed by pipeline controller): req is deasserted or carries a new access in the cycle after its done pulse; arbiter treats req high in IDLE as a new access.
- Reset values: state IDLE, all bus_* 0, if/mem_done_o 0, err_o 0, rdata registers 0, discard 0, counter 0.
- Reset mid-transaction: bus_req_o drops asynchronously; slave tolerates abandoned cycle.

## Timing
- Request seen in IDLE at cycle 0 → bus_req_o high cycle 1.
- bus_ack_i in cycle n (n≥1) → done pulse and rdata valid in cycle n+1; bus_req_o low in n+1.
- Minimum latency req→done: 2 cycles; back-to-back throughput: one access per 3 cycles minimum.
- No combinational path bus_ack_i → bus_req_o or done.

## Configuration
- ARB_BUS_TIMEOUT_EN defined: counter increments each BUS cycle without ack, clears on leaving BUS; reaching TIMEOUT_CYCLES → go RESP, rdata=0, done pulse (subject to discard) with err_o pulse in same cycle. Ack in the same cycle as terminal count wins (normal completion, no err).
- Undefined: no counter, BUS waits indefinitely, err_o tied 0.

## Structure
- Shared package: state encoding (IDLE/BUS/RESP), owner encoding (IF/MEM), ZeroWord, full-byte select constant.
- One sub-module: bus_watchdog (8-bit timeout counter, start/clear/expire), instantiated only under ARB_BUS_TIMEOUT_EN.

## Test plan
- IF read 0x0000_0100, ack next cycle with 0x2402_0005 → bus_req_o cycle 1, if_done_o and if_rdata_o=0x2402_0005 cycle 3 (ack cycle 2), stallreq_o high cycles 0–2.
- IF and MEM store (0x8000_0004, data 0xDEAD_BEEF, sel 4'b0011) same cycle → MEM issued first with bus_we_o=1, mem_done_o; IF issued next IDLE; no overlap of bus_req_o.
- IF in flight, flush_i pulsed during BUS, ack 0x1234_5678 → no if_done_o, if_rdata_o unchanged; new IF request afterwards completes normally.
- MEM load, bus_ack_i withheld, TIMEOUT_CYCLES=4, macro on → abort after 4 BUS cycles, mem_done_o+err_o same cycle, mem_rdata_o=0; macro off → bus_req_o stays high.
- rst driven low during BUS → bus_req_o, done, err_o 0 immediately; after release, IDLE accepts fresh request.
- Ack delayed 5 cycles → bus_addr/wdata/sel stable whole BUS phase, done exactly one cycle.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Optional bus timeout abort is enabled by defining ARB_BUS_TIMEOUT_EN.
package mem_bus_arbiter_pkg;

  // Bus sequencer states: one transaction at a time.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  // Requester that owns the transaction currently on the bus.
  typedef enum logic {
    OwnIf  = 1'b0,
    OwnMem = 1'b1
  } owner_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [3:0]  SelAll   = 4'hF;

  // Width of the timeout counter; TIMEOUT_CYCLES must fit (1..255).
  localparam int unsigned WdtWidth = 8;

endpackage

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Bus watchdog: counts cycles a bus strobe waits without acknowledge and
// flags expiry on the cycle the count reaches Limit.
// Only instantiated when ARB_BUS_TIMEOUT_EN is defined.
module mem_bus_arbiter_bus_watchdog #(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expire
);
  import mem_bus_arbiter_pkg::*;

  localparam logic [WdtWidth-1:0] LastCount = WdtWidth'(Limit - 1);

  logic [WdtWidth-1:0] cnt_q, cnt_d;

  // Expiry fires on the Limit-th waiting cycle, so the caller aborts after exactly Limit cycles.
  assign expire = start && (cnt_q == LastCount);

  // Next count: clear wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one external bus between instruction fetch (IF)
// and data access (MEM). MEM has fixed priority; a flush discards an in-flight
// fetch response. Define ARB_BUS_TIMEOUT_EN to abort unacknowledged cycles
// after TIMEOUT_CYCLES with an err_o pulse.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_done_o,
  output logic [31:0] if_rdata_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic        mem_done_o,
  output logic [31:0] mem_rdata_o,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);
  import mem_bus_arbiter_pkg::*;

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        discard_q, discard_d;
  logic        err_q, err_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        timeout;
  logic        in_bus;
  logic        in_resp;

  assign in_bus  = (state_q == StBus);
  assign in_resp = (state_q == StResp);

`ifdef ARB_BUS_TIMEOUT_EN
  // Counts only waiting BUS cycles; an ack in the terminal cycle suppresses expiry.
  mem_bus_arbiter_bus_watchdog #(
    .Limit (TIMEOUT_CYCLES)
  ) u_bus_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (in_bus && !bus_ack_i),
    .clear  (!in_bus),
    .expire (timeout)
  );
`else
  assign timeout = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Next-state logic for the bus sequencer, bus latches and read-data registers.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    discard_d   = discard_q;
    err_d       = err_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      StIdle: begin
        discard_d = 1'b0;
        err_d     = 1'b0;
        if (mem_req_i) begin
          owner_d     = OwnMem;
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
          bus_sel_d   = mem_sel_i;
          state_d     = StBus;
        end else if (if_req_i && !flush_i) begin
          owner_d     = OwnIf;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = ZeroWord;
          bus_sel_d   = SelAll;
          state_d     = StBus;
        end
      end
      StBus: begin
        // A flushed fetch still completes on the bus; only its response is dropped.
        if (owner_q == OwnIf && flush_i) begin
          discard_d = 1'b1;
        end
        if (bus_ack_i) begin
          state_d = StResp;
          if (owner_q == OwnMem) begin
            mem_rdata_d = bus_we_q ? ZeroWord : bus_rdata_i;
          end else if (!discard_d) begin
            if_rdata_d = bus_rdata_i;
          end
        end else if (timeout) begin
          state_d = StResp;
          err_d   = 1'b1;
          if (owner_q == OwnMem) begin
            mem_rdata_d = ZeroWord;
          end else if (!discard_d) begin
            if_rdata_d = ZeroWord;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      discard_q   <= 1'b0;
      err_q       <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= ZeroWord;
      bus_wdata_q <= ZeroWord;
      bus_sel_q   <= 4'h0;
      if_rdata_q  <= ZeroWord;
      mem_rdata_q <= ZeroWord;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      discard_q   <= discard_d;
      err_q       <= err_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Outputs decode from registered state only, so bus_ack_i never reaches them combinationally.
  always_comb begin
    bus_req_o   = in_bus;
    bus_we_o    = bus_we_q;
    bus_addr_o  = bus_addr_q;
    bus_wdata_o = bus_wdata_q;
    bus_sel_o   = bus_sel_q;
    // A flush in the response cycle also cancels the fetch done pulse.
    if_done_o   = in_resp && (owner_q == OwnIf) && !discard_q && !flush_i;
    mem_done_o  = in_resp && (owner_q == OwnMem);
    err_o       = err_q && (if_done_o || mem_done_o);
    if_rdata_o  = if_rdata_q;
    mem_rdata_o = mem_rdata_q;
    stallreq_o  = (if_req_i && !if_done_o && !flush_i) || (mem_req_i && !mem_done_o);
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int unsigned TimeoutCycles = 4;
`ifdef ARB_BUS_TIMEOUT_EN
  localparam int LongDly = 3;
`else
  localparam int LongDly = 5;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done_o;
  logic [31:0] if_rdata_o;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_sel = '0;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;
  logic        flush = 1'b0;
  logic        stallreq_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_done_o   (if_done_o),
    .if_rdata_o  (if_rdata_o),
    .mem_req_i   (mem_req),
    .mem_we_i    (mem_we),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_sel_i   (mem_sel),
    .mem_done_o  (mem_done_o),
    .mem_rdata_o (mem_rdata_o),
    .flush_i     (flush),
    .stallreq_o  (stallreq_o),
    .err_o       (err_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_sel_o   (bus_sel_o),
    .bus_ack_i   (bus_ack),
    .bus_rdata_i (bus_rdata)
  );

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          dly;
    logic [31:0] ack_data;
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  // Slave read-data pattern for the random run.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One isolated transaction from IDLE, checked cycle by cycle.
  task automatic run_vec(input vec_t v, input string tag);
    @(posedge clk); #1;
    mem_we    = v.we;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    mem_sel   = v.sel;
    if (v.is_mem) mem_req = 1'b1;
    else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    @(negedge clk);
    chk($sformatf("%s c0 bus_req", tag), 32'(bus_req_o), 32'd0);
    chk($sformatf("%s c0 stall", tag), 32'(stallreq_o), 32'd1);
    for (int c = 1; c <= v.dly; c++) begin
      @(posedge clk); #1;
      bus_ack   = (c == v.dly);
      bus_rdata = bus_ack ? v.ack_data : (32'hBAD0_0000 + 32'(c));
      @(negedge clk);
      chk($sformatf("%s c%0d bus_req", tag, c), 32'(bus_req_o), 32'd1);
      chk($sformatf("%s c%0d bus_addr", tag, c), bus_addr_o, v.addr);
      chk($sformatf("%s c%0d bus_we", tag, c), 32'(bus_we_o), 32'(v.exp_we));
      chk($sformatf("%s c%0d bus_sel", tag, c), 32'(bus_sel_o), 32'(v.exp_sel));
      if (v.is_mem) chk($sformatf("%s c%0d bus_wdata", tag, c), bus_wdata_o, v.wdata);
      chk($sformatf("%s c%0d stall", tag, c), 32'(stallreq_o), 32'd1);
      chk($sformatf("%s c%0d done", tag, c), 32'(if_done_o | mem_done_o), 32'd0);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk($sformatf("%s resp bus_req", tag), 32'(bus_req_o), 32'd0);
    chk($sformatf("%s resp if_done", tag), 32'(if_done_o), 32'(!v.is_mem));
    chk($sformatf("%s resp mem_done", tag), 32'(mem_done_o), 32'(v.is_mem));
    chk($sformatf("%s resp rdata", tag), v.is_mem ? mem_rdata_o : if_rdata_o, v.exp_rdata);
    chk($sformatf("%s resp stall", tag), 32'(stallreq_o), 32'd0);
    chk($sformatf("%s resp err", tag), 32'(err_o), 32'd0);
    @(posedge clk); #1;
    if_req  = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);
    chk($sformatf("%s idle done", tag), 32'(if_done_o | mem_done_o), 32'd0);
    chk($sformatf("%s idle bus_req", tag), 32'(bus_req_o), 32'd0);
  endtask

  // Random-run model state.
  logic        exp_if_cur, exp_if_next, exp_mem_cur, exp_mem_next;
  logic [31:0] exp_if_dcur, exp_if_dnext, exp_mem_dcur, exp_mem_dnext;
  logic        last_if_done, last_mem_done;
  logic        in_txn, t_mem, t_we;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_sel;
  int          bus_cnt, ack_at, if_wait, mem_wait;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'h1357_9BDF, 4'h3, 2, 32'h2402_0005,
                1'b0, 4'hF, 32'h2402_0005};
    vecs[1] = '{1'b1, 1'b0, 32'h1000_0008, 32'h0000_0000, 4'hF, 1, 32'hCAFE_F00D,
                1'b0, 4'hF, 32'hCAFE_F00D};
    vecs[2] = '{1'b1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b0011, LongDly, 32'hFFFF_FFFF,
                1'b1, 4'b0011, 32'h0000_0000};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0204, 32'h0000_0000, 4'h0, 1, 32'h0BAD_CAFE,
                1'b0, 4'hF, 32'h0BAD_CAFE};
    vecs[4] = '{1'b1, 1'b0, 32'h2000_0010, 32'h0000_0000, 4'b0100, 3, 32'h00AB_0000,
                1'b0, 4'b0100, 32'h00AB_0000};

    // Reset state.
    #3;
    chk("rst bus_req", 32'(bus_req_o), 32'd0);
    chk("rst bus_we", 32'(bus_we_o), 32'd0);
    chk("rst bus_addr", bus_addr_o, 32'd0);
    chk("rst bus_wdata", bus_wdata_o, 32'd0);
    chk("rst bus_sel", 32'(bus_sel_o), 32'd0);
    chk("rst dones", 32'({if_done_o, mem_done_o}), 32'd0);
    chk("rst err", 32'(err_o), 32'd0);
    chk("rst if_rdata", if_rdata_o, 32'd0);
    chk("rst mem_rdata", mem_rdata_o, 32'd0);
    chk("rst stall", 32'(stallreq_o), 32'd0);
    #9 rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Unacknowledged MEM load.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000_0000; mem_sel = 4'hF;
    @(negedge clk);
`ifdef ARB_BUS_TIMEOUT_EN
    for (int c = 1; c <= int'(TimeoutCycles); c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("to c%0d bus_req", c), 32'(bus_req_o), 32'd1);
      chk($sformatf("to c%0d done_err", c), 32'({mem_done_o, err_o}), 32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("to abort mem_done", 32'(mem_done_o), 32'd1);
    chk("to abort err", 32'(err_o), 32'd1);
    chk("to abort rdata", mem_rdata_o, 32'd0);
    chk("to abort bus_req", 32'(bus_req_o), 32'd0);
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    chk("to after done_err", 32'({mem_done_o, err_o}), 32'd0);
`else
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("hold c%0d bus_req", c), 32'(bus_req_o), 32'd1);
      chk($sformatf("hold c%0d done_err", c), 32'({mem_done_o, err_o}), 32'd0);
    end
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h4444_0000;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("hold mem_done", 32'(mem_done_o), 32'd1);
    chk("hold rdata", mem_rdata_o, 32'h4444_0000);
    chk("hold err", 32'(err_o), 32'd0);
    @(posedge clk); #1;
    mem_req = 1'b0;
`endif

    // IF and MEM store in the same cycle: MEM first, then IF, never overlapping.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0004;
    mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'b0011;
    if_req = 1'b1; if_addr = 32'h0000_0300;
    @(negedge clk);
    chk("both c0 bus_req", 32'(bus_req_o), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("both mem bus_req", 32'(bus_req_o), 32'd1);
    chk("both mem we", 32'(bus_we_o), 32'd1);
    chk("both mem addr", bus_addr_o, 32'h8000_0004);
    chk("both mem wdata", bus_wdata_o, 32'hDEAD_BEEF);
    chk("both mem sel", 32'(bus_sel_o), 32'h3);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("both mem_done", 32'(mem_done_o), 32'd1);
    chk("both mem_rdata", mem_rdata_o, 32'd0);
    chk("both if_done early", 32'(if_done_o), 32'd0);
    chk("both resp bus_req", 32'(bus_req_o), 32'd0);
    chk("both resp stall", 32'(stallreq_o), 32'd1);
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    chk("both gap bus_req", 32'(bus_req_o), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h0F0F_1234;
    @(negedge clk);
    chk("both if bus_req", 32'(bus_req_o), 32'd1);
    chk("both if we", 32'(bus_we_o), 32'd0);
    chk("both if addr", bus_addr_o, 32'h0000_0300);
    chk("both if sel", 32'(bus_sel_o), 32'hF);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("both if_done", 32'(if_done_o), 32'd1);
    chk("both if_rdata", if_rdata_o, 32'h0F0F_1234);
    chk("both if mem_done", 32'(mem_done_o), 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0;

    // Flush during an in-flight fetch discards its response.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0500;
    @(posedge clk); #1;
    flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    chk("flush bus_req", 32'(bus_req_o), 32'd1);
    chk("flush stall", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("flush if_done", 32'(if_done_o), 32'd0);
    chk("flush if_rdata", if_rdata_o, 32'h0F0F_1234);
    chk("flush resp bus_req", 32'(bus_req_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush idle if_done", 32'(if_done_o), 32'd0);
    run_vec('{1'b0, 1'b0, 32'h0000_0504, 32'h0, 4'h0, 1, 32'h7777_0001,
              1'b0, 4'hF, 32'h7777_0001}, "postflush");

    // Asynchronous reset in the middle of a bus cycle.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0040; mem_sel = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst pre bus_req", 32'(bus_req_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst bus_req", 32'(bus_req_o), 32'd0);
    chk("arst done_err", 32'({if_done_o, mem_done_o, err_o}), 32'd0);
    chk("arst bus_addr", bus_addr_o, 32'd0);
    chk("arst if_rdata", if_rdata_o, 32'd0);
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_vec(vecs[1], "postrst");

    // Randomized traffic against a transaction-level model.
    exp_if_cur = 0; exp_if_next = 0; exp_mem_cur = 0; exp_mem_next = 0;
    exp_if_dcur = 0; exp_if_dnext = 0; exp_mem_dcur = 0; exp_mem_dnext = 0;
    in_txn = 0; t_mem = 0; t_we = 0; t_addr = 0; t_wdata = 0; t_sel = 0;
    bus_cnt = 0; ack_at = 1; if_wait = 0; mem_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      last_if_done  = exp_if_cur;
      last_mem_done = exp_mem_cur;
      exp_if_cur    = exp_if_next;  exp_if_dcur  = exp_if_dnext;  exp_if_next  = 1'b0;
      exp_mem_cur   = exp_mem_next; exp_mem_dcur = exp_mem_dnext; exp_mem_next = 1'b0;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      if (in_txn) chk("rnd bus_req held", 32'(bus_req_o), 32'd1);
      if (bus_req_o) begin
        if (!in_txn) begin
          // Owner is decided from the requests of the previous (IDLE) cycle.
          chk("rnd bus source", 32'(if_req | mem_req), 32'd1);
          in_txn = 1'b1;
          bus_cnt = 0;
          ack_at = int'($urandom_range(1, 3));
          t_mem = mem_req;
          t_we = mem_req ? mem_we : 1'b0;
          t_addr = mem_req ? mem_addr : if_addr;
          t_wdata = mem_wdata;
          t_sel = mem_req ? mem_sel : 4'hF;
        end
        chk("rnd bus_we", 32'(bus_we_o), 32'(t_we));
        chk("rnd bus_addr", bus_addr_o, t_addr);
        chk("rnd bus_sel", 32'(bus_sel_o), 32'(t_sel));
        if (t_mem) chk("rnd bus_wdata", bus_wdata_o, t_wdata);
        bus_cnt++;
        if (bus_cnt == ack_at) begin
          bus_ack   = 1'b1;
          bus_rdata = t_we ? $urandom : rd_fn(t_addr);
          if (t_mem) begin
            exp_mem_next  = 1'b1;
            exp_mem_dnext = t_we ? 32'd0 : rd_fn(t_addr);
          end else begin
            exp_if_next  = 1'b1;
            exp_if_dnext = rd_fn(t_addr);
          end
          in_txn = 1'b0;
        end
      end else begin
        bus_ack = ($urandom_range(0, 3) == 0);
      end
      if (last_mem_done || !mem_req) begin
        mem_req   = ($urandom_range(0, 2) == 0);
        mem_we    = 1'($urandom_range(0, 1));
        mem_addr  = $urandom & 32'hFFFF_FFFC;
        mem_wdata = $urandom;
        mem_sel   = 4'($urandom_range(1, 15));
      end
      if (last_if_done || !if_req) begin
        if_req  = ($urandom_range(0, 1) == 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      @(negedge clk);
      chk("rnd if_done", 32'(if_done_o), 32'(exp_if_cur));
      if (exp_if_cur) chk("rnd if_rdata", if_rdata_o, exp_if_dcur);
      chk("rnd mem_done", 32'(mem_done_o), 32'(exp_mem_cur));
      if (exp_mem_cur) chk("rnd mem_rdata", mem_rdata_o, exp_mem_dcur);
      chk("rnd err", 32'(err_o), 32'd0);
      chk("rnd stall", 32'(stallreq_o),
          32'((if_req && !exp_if_cur) || (mem_req && !exp_mem_cur)));
      if (if_req && !exp_if_cur) if_wait++;
      else if_wait = 0;
      if (mem_req && !exp_mem_cur) mem_wait++;
      else mem_wait = 0;
      if (if_wait > 200) begin
        chk("rnd if wait bound", 32'(if_wait), 32'd200);
        if_wait = 0;
      end
      if (mem_wait > 20) begin
        chk("rnd mem wait bound", 32'(mem_wait), 32'd20);
        mem_wait = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
